// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce bank.
package debounce_pkg;
  typedef enum logic {STABLE = 1'b0, WAIT = 1'b1} ch_state_t;

  localparam int DEF_TICK_M       = 1_000_000;
  localparam int DEF_STABLE_TICKS = 3;
endpackage

// File: rtl/db_tick_gen.sv
// Free-running mod-M counter; tick pulses for one cycle at count M-1.
module db_tick_gen #(
  parameter int M = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int            W    = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0]  LAST = W'(M - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: wrap to 0 after M-1
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/debounce_bank_ctrl.sv
// Bank of tick-based switch debouncers with a round-robin edge-event queue.
module debounce_bank_ctrl
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_M       = DEF_TICK_M,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           sw,
  output logic [N_CH-1:0]           db,
  output logic                      evt_valid,
  output logic [$clog2(N_CH)-1:0]   evt_ch,
  output logic                      evt_rise,
  input  logic                      evt_ack,
  output logic                      overrun
);
  localparam int                CH_W     = $clog2(N_CH);
  localparam int                CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

  logic              tick;
  logic [N_CH-1:0]   sync1_q, sw_s_q;
  logic [N_CH-1:0]   db_q, db_nxt, accept;
  logic [N_CH-1:0]   pending_q, pending_d, dir_q, dir_d, clr;
  logic              evt_valid_q, evt_valid_d, evt_rise_q, evt_rise_d;
  logic              overrun_q, overrun_d, found;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d, rr_q, rr_d, gnt_ch, cand;

  db_tick_gen #(.M(TICK_M)) u_tick (.clk(clk), .reset(reset), .tick(tick));

  // two-flop synchronizer on the raw switch levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sw_s_q  <= '0;
    end else begin
      sync1_q <= sw;
      sw_s_q  <= sync1_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_bit_q, db_d, acc;

    // per-channel debounce FSM: a changed level must survive STABLE_TICKS ticks
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_bit_q;
      acc     = 1'b0;
      case (state_q)
        STABLE: if (sw_s_q[c] != db_bit_q) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: if (sw_s_q[c] == db_bit_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE;
            cnt_d   = '0;
            db_d    = ~db_bit_q;
            acc     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = STABLE;
      endcase
    end

    // per-channel state registers
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= STABLE;
        cnt_q    <= '0;
        db_bit_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        db_bit_q <= db_d;
      end
    end

    assign db_q[c]   = db_bit_q;
    assign db_nxt[c] = db_d;
    assign accept[c] = acc;
  end

  // round-robin pick of the first pending channel at or above rr_q
  always_comb begin
    found  = 1'b0;
    gnt_ch = '0;
    cand   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = CH_W'((int'(rr_q) + i) % N_CH);
      if (!found && pending_q[cand]) begin
        found  = 1'b1;
        gnt_ch = cand;
      end
    end
  end

  // event handshake, pending/dir bookkeeping; a fresh acceptance beats a grant clear
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    rr_d        = rr_q;
    clr         = '0;
    if (!evt_valid_q) begin
      if (found) begin
        evt_valid_d  = 1'b1;
        evt_ch_d     = gnt_ch;
        evt_rise_d   = dir_q[gnt_ch];
        clr[gnt_ch]  = 1'b1;
      end
    end else if (evt_ack) begin
      evt_valid_d = 1'b0;
      rr_d        = (evt_ch_q == CH_LAST) ? '0 : evt_ch_q + CH_W'(1);
    end
    pending_d = (pending_q & ~clr) | accept;
    dir_d     = (dir_q & ~accept) | (db_nxt & accept);
    // an event still waiting (not being granted right now) gets overwritten
    overrun_d = overrun_q | (|(accept & pending_q & ~clr));
  end

  // arbiter and event registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      dir_q       <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      dir_q       <= dir_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      overrun_q   <= overrun_d;
    end
  end

  assign db        = db_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_debounce_bank_ctrl.sv
// Self-checking bench: randomized and directed stimulus against an event-level model.
module tb_debounce_bank_ctrl;
  import debounce_pkg::*;

  localparam int N  = 4;
  localparam int M  = 10;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sw = '0;
  logic         evt_ack = 1'b0;
  logic [N-1:0] db;
  logic         evt_valid, evt_rise, overrun;
  logic [1:0]   evt_ch;
  logic [8:0]   got;

  int checks = 0;
  int failures = 0;

  debounce_bank_ctrl #(.N_CH(N), .TICK_M(M), .STABLE_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .evt_valid(evt_valid),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .evt_ack(evt_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  assign got = {db, evt_valid, evt_ch, evt_rise, overrun};

  // reference model state: plain integers per channel
  int m_s1[N], m_s2[N], m_db[N], m_age[N], m_tk[N], m_pend[N], m_dir[N];
  int m_tc, m_ev, m_ch, m_rise, m_rr, m_ovr;

  // advance the model by one clock using the inputs present before the edge, then clock the DUT
  task automatic step();
    int tick, g;
    int acc[N];
    int clr[N];
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_age[c] = 0;
        m_tk[c] = 0; m_pend[c] = 0; m_dir[c] = 0;
      end
      m_tc = 0; m_ev = 0; m_ch = 0; m_rise = 0; m_rr = 0; m_ovr = 0;
    end else begin
      tick = (m_tc == M - 1) ? 1 : 0;
      m_tc = (m_tc + 1) % M;
      for (int c = 0; c < N; c++) begin
        acc[c] = 0; clr[c] = 0;
        if (m_s2[c] != m_db[c]) begin
          // ticks only count once the change has been seen for a full cycle
          if (m_age[c] > 0 && tick == 1) m_tk[c]++;
          if (m_tk[c] == ST) begin
            acc[c] = 1; m_db[c] = m_s2[c]; m_age[c] = 0; m_tk[c] = 0;
          end else m_age[c]++;
        end else begin
          m_age[c] = 0; m_tk[c] = 0;
        end
      end
      g = -1;
      if (m_ev == 0) begin
        for (int i = 0; i < N; i++)
          if (g < 0 && m_pend[(m_rr + i) % N] == 1) g = (m_rr + i) % N;
        if (g >= 0) begin
          m_ev = 1; m_ch = g; m_rise = m_dir[g]; clr[g] = 1;
        end
      end else if (evt_ack) begin
        m_ev = 0; m_rr = (m_ch + 1) % N;
      end
      for (int c = 0; c < N; c++) begin
        if (acc[c] == 1) begin
          if (m_pend[c] == 1 && clr[c] == 0) m_ovr = 1;
          m_pend[c] = 1; m_dir[c] = m_db[c];
        end else if (clr[c] == 1) m_pend[c] = 0;
      end
      for (int c = 0; c < N; c++) begin
        m_s2[c] = m_s1[c]; m_s1[c] = int'(sw[c]);
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [N-1:0] d;
    for (int c = 0; c < N; c++) d[c] = m_db[c][0];
    return {d, m_ev[0], 2'(m_ch), m_rise[0], m_ovr[0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1; sw = '0; evt_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = '0; evt_ack = 1'b0;
    step(); step();
    checks++;
    if (got !== 9'h000) begin
      failures++; $display("FAIL reset_outputs got=%h exp=000", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    int lat = -1, nev = 0, ech = -1, erise = -1;
    do_reset();
    evt_ack = 1'b1;
    sw[1] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL clean_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
      if (lat < 0 && db[1]) lat = k;
      if (evt_valid) begin nev++; ech = evt_ch; erise = evt_rise; end
    end
    // edges counted from the cycle sw is driven, including the WAIT-entry edge
    checks++;
    if (lat < 24 || lat > 33) begin
      failures++; $display("FAIL clean_latency got=%0d exp=24..33", lat);
    end
    checks++;
    if (nev != 1 || ech != 1 || erise != 1) begin
      failures++; $display("FAIL clean_event got n=%0d ch=%0d rise=%0d exp n=1 ch=1 rise=1", nev, ech, erise);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    do_reset();
    evt_ack = 1'b1;
    sw[2] = 1'b1;
    for (int k = 0; k < 55; k++) begin
      if (k == 15) sw[2] = 1'b0;
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL glitch_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
      if (db[2] || evt_valid) bad++;
    end
    checks++;
    if (bad != 0 || dut.g_ch[2].state_q !== STABLE) begin
      failures++; $display("FAIL glitch_reject got bad=%0d state=%0d exp bad=0 state=0", bad, dut.g_ch[2].state_q);
    end
  endtask

  task automatic test_simultaneous();
    int t[2], c[2], n = 0;
    do_reset();
    evt_ack = 1'b1;
    sw[0] = 1'b1; sw[3] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL simul_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
      if (evt_valid && n < 2) begin t[n] = k; c[n] = evt_ch; n++; end
    end
    checks++;
    if (n != 2 || c[0] != 0 || c[1] != 3 || t[1] - t[0] != 2) begin
      failures++; $display("FAIL simul_order got n=%0d ch=%0d,%0d gap=%0d exp n=2 ch=0,3 gap=2", n, c[0], c[1], t[1] - t[0]);
    end
  endtask

  task automatic test_backpressure_overrun();
    int moved = 0, seen = 0;
    do_reset();
    sw[0] = 1'b1;
    for (int k = 0; k < 60 && !evt_valid; k++) step();
    checks++;
    if (!evt_valid) begin
      failures++; $display("FAIL bp_first_event got valid=0 exp valid=1 (timeout)");
    end
    for (int k = 0; k < 80; k++) begin
      sw[1] = (k < 40);
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL bp_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
      if (!evt_valid || evt_ch != 2'd0 || !evt_rise) moved++;
    end
    checks++;
    if (moved != 0 || overrun !== 1'b1) begin
      failures++; $display("FAIL bp_hold got moved=%0d overrun=%b exp moved=0 overrun=1", moved, overrun);
    end
    evt_ack = 1'b1; step(); evt_ack = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (evt_valid) seen = 1;
    end
    checks++;
    if (seen != 1 || evt_ch !== 2'd1 || evt_rise !== 1'b0) begin
      failures++; $display("FAIL bp_second_event got seen=%0d ch=%0d rise=%b exp seen=1 ch=1 rise=0", seen, evt_ch, evt_rise);
    end
  endtask

  task automatic test_round_robin();
    int g[$];
    do_reset();
    evt_ack = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sw[1:0] = ~sw[1:0];
      for (int k = 0; k < 50; k++) begin
        step();
        checks++;
        if (got !== exp_vec()) begin
          failures++; $display("FAIL rr_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
        end
        if (evt_valid) g.push_back(int'(evt_ch));
      end
    end
    checks++;
    if (g.size() != 4 || g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1) begin
      failures++; $display("FAIL rr_order got n=%0d exp 0,1,0,1", g.size());
    end
  endtask

  task automatic test_reset_mid();
    int first_ch = -1, first_rise = -1;
    do_reset();
    sw[0] = 1'b1;
    for (int k = 0; k < 60 && !evt_valid; k++) step();
    sw[2] = 1'b1;
    repeat (12) step();
    reset = 1'b1;
    step();
    checks++;
    if (got !== 9'h000 || dut.u_tick.cnt_q !== 4'd0) begin
      failures++; $display("FAIL reset_mid got=%h tick_cnt=%0d exp=000 tick_cnt=0", got, dut.u_tick.cnt_q);
    end
    reset = 1'b0;
    // sw[0] and sw[2] stay high through release and must re-debounce
    for (int k = 0; k < 60; k++) begin
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL reset_mid_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
      if (evt_valid && first_ch < 0) begin first_ch = evt_ch; first_rise = evt_rise; end
    end
    checks++;
    if (first_ch != 0 || first_rise != 1) begin
      failures++; $display("FAIL reset_release_event got ch=%0d rise=%0d exp ch=0 rise=1", first_ch, first_rise);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 39) == 0) sw[c] = ~sw[c];
      evt_ack = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 1499) == 0);
      step();
      checks++;
      if (got !== exp_vec()) begin
        failures++; $display("FAIL random_model got=%h exp=%h cyc=%0d", got, exp_vec(), k);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_backpressure_overrun();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/debounce_bank_ctrl.md
DEBOUNCE_BANK_CTRL -- requirements
Module: debounce_bank_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of switch channels, range 2..16.
REQ-002 Parameter TICK_M, default 1_000_000: tick period in clk cycles (10 ms at 100 MHz).
REQ-003 Parameter STABLE_TICKS, default 3: consecutive ticks of a stable changed level needed to accept it.
REQ-004 clk  input  1  system clock; one clock domain; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw  input  N_CH  raw, asynchronous switch levels.
REQ-007 db  output  N_CH  debounced levels, one bit per channel.
REQ-008 evt_valid  output  1  an edge event is presented.
REQ-009 evt_ch  output  $clog2(N_CH)  channel index of the presented event.
REQ-010 evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-011 evt_ack  input  1  consumer accepts the presented event.
REQ-012 overrun  output  1  sticky flag: an unconsumed event on some channel was overwritten.

Function
REQ-013 Each sw bit SHALL pass through a 2-flop synchronizer before any other logic; the synchronized level is sw_s.
REQ-014 One shared tick generator SHALL count 0..TICK_M-1 and wrap to 0; tick is high for exactly one cycle when the count equals TICK_M-1.
REQ-015 Each channel SHALL run an independent FSM with states STABLE and WAIT, plus a counter cnt of width $clog2(STABLE_TICKS+1).
REQ-016 STABLE, sw_s != db: go to WAIT with cnt=0. STABLE, sw_s == db: stay in STABLE.
REQ-017 WAIT, sw_s == db: return to STABLE with cnt=0; db is unchanged and no event is raised (glitch rejected).
REQ-018 WAIT, sw_s != db, tick=1, cnt == STABLE_TICKS-1:
- db toggles on the next cycle;
- state returns to STABLE and cnt clears;
- pending[ch] is set and dir[ch] takes the new db value.
REQ-019 WAIT, sw_s != db, tick=1, cnt < STABLE_TICKS-1: cnt increments. With tick=0: hold.
REQ-020 Acceptance latency from an sw change SHALL be 2 sync cycles plus between (STABLE_TICKS-1)*TICK_M+1 and STABLE_TICKS*TICK_M cycles.
REQ-021 Arbiter, when evt_valid=0 and pending != 0:
- select the first pending channel scanning upward from rr_ptr, with wrap-around;
- register evt_ch and evt_rise=dir[ch] and set evt_valid on the next cycle;
- clear that channel's pending bit in the same cycle.
REQ-022 While evt_valid=1 and evt_ack=0, evt_ch and evt_rise SHALL hold stable.
REQ-023 evt_valid=1 and evt_ack=1: evt_valid deasserts next cycle and rr_ptr becomes (evt_ch+1) mod N_CH; one idle cycle SHALL separate consecutive events.
REQ-024 evt_ack while evt_valid=0 SHALL be ignored.
REQ-025 A new acceptance on a channel whose pending bit is already 1 SHALL overwrite dir and set overrun; overrun clears only by reset.
REQ-026 If a channel's pending bit is set and cleared in the same cycle, set SHALL win.
REQ-027 Simultaneous acceptances on several channels in one cycle SHALL each set their own pending bit; none is lost.

Reset
REQ-028 Reset SHALL clear all of: synchronizer flops, tick counter, every FSM to STABLE, cnt, db, pending, dir, rr_ptr, evt_valid, evt_ch, evt_rise and overrun.
REQ-029 Reset asserted mid-debounce or mid-handshake SHALL take effect on the next edge and drop the presented event.
REQ-030 A channel held at sw=1 through reset release SHALL raise a rising event after normal debounce latency.

Structure
REQ-031 Package debounce_pkg SHALL hold typedef enum ch_state_t {STABLE, WAIT} and default constants DEF_TICK_M and DEF_STABLE_TICKS.
REQ-032 One sub-module, db_tick_gen (parameterized mod-M counter with synchronous reset and a tick output), SHALL be instantiated once; per-channel FSMs are a generate loop within debounce_bank_ctrl.

Verification (TICK_M=10, STABLE_TICKS=3, N_CH=4)
REQ-033 Clean press: sw[1] 0->1 and held -> db[1]=1 within 2+21..2+30 cycles; one event, evt_ch=1, evt_rise=1.
REQ-034 Glitch: sw[2] high for 15 cycles, then low -> db[2] stays 0; no event; FSM back in STABLE.
REQ-035 Simultaneous: sw[0] and sw[3] rise in the same cycle, evt_ack tied 1 -> events ch0 then ch3, separated by one idle cycle.
REQ-036 Backpressure and overrun: evt_ack=0 while ch0 presses, a ch1 press is accepted, then ch1 releases -> ch0 held stable; overrun=1; after ack, ch1 event has evt_rise=0.
REQ-037 Round-robin fairness: ch0 and ch1 retoggled continuously, acked each time -> grants alternate 0,1,0,1.
REQ-038 Reset mid-operation: reset during WAIT with evt_valid=1 -> next cycle all outputs are 0 and the tick count restarts at 0.
